// File: rtl/zion_riscv_isa_lib_pkg.sv
// Shared types and helpers for the load path: access sizes, LSU states,
// one-hot size decode and the alignment rule.
package zion_riscv_isa_lib_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } load_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } lsu_state_e;

    function automatic logic [3:0] size_to_load_en(load_size_e size);
        return 4'b0001 << size;
    endfunction

    // Doublewords are always illegal on a 32-bit datapath, aligned or not.
    function automatic logic is_misaligned(load_size_e size, logic [2:0] addr, logic rv64);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_H:  mis = addr[0];
            SIZE_W:  mis = |addr[1:0];
            SIZE_D:  mis = (|addr[2:0]) | ~rv64;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/zion_riscv_isa_lib_load_mem_access_if.sv
// Request, data-memory and extract-stage hand-off signals of the load
// memory-access stage; master is the stage, slave is its environment.
interface zion_riscv_isa_lib_load_mem_access_if #(
    parameter int RV64       = 0,
    parameter int ADDR_WIDTH = 32
);
    logic                      req_vld;
    logic                      req_rdy;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic                      mem_req_vld;
    logic                      mem_req_rdy;
    logic [ADDR_WIDTH-1:0]     mem_req_addr;
    logic                      mem_rsp_vld;
    logic [32*(RV64+1)-1:0]    mem_rsp_dat;
    logic                      mem_rsp_err;
    logic                      ld_vld;
    logic                      ld_rdy;
    logic [2+RV64:0]           ld_load_en;
    logic                      ld_unsigned;
    logic [1+RV64:0]           ld_addr;
    logic [32*(RV64+1)-1:0]    ld_mem_dat;
    logic                      ld_misalign;
    logic                      ld_fault;

    modport master (
        input  req_vld, req_addr, req_size, req_unsigned,
        input  mem_req_rdy, mem_rsp_vld, mem_rsp_dat, mem_rsp_err,
        input  ld_rdy,
        output req_rdy, mem_req_vld, mem_req_addr,
        output ld_vld, ld_load_en, ld_unsigned, ld_addr, ld_mem_dat, ld_misalign, ld_fault
    );

    modport slave (
        output req_vld, req_addr, req_size, req_unsigned,
        output mem_req_rdy, mem_rsp_vld, mem_rsp_dat, mem_rsp_err,
        output ld_rdy,
        input  req_rdy, mem_req_vld, mem_req_addr,
        input  ld_vld, ld_load_en, ld_unsigned, ld_addr, ld_mem_dat, ld_misalign, ld_fault
    );

endinterface

// File: rtl/zion_riscv_isa_lib_load_mem_access.sv
// Load memory-access stage: checks alignment, issues one word-aligned read,
// captures the response and hands the result to the extract stage.
module zion_riscv_isa_lib_load_mem_access
    import zion_riscv_isa_lib_pkg::*;
#(
    parameter int RV64       = 0,
    parameter int ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    zion_riscv_isa_lib_load_mem_access_if.master bus
);

    localparam int CPU_WIDTH = 32 * (RV64 + 1);
    localparam int LOW_BITS  = 2 + RV64;
    localparam int EN_W      = 3 + RV64;

    lsu_state_e            state;
    lsu_state_e            nextState;
    load_size_e            sizeQ;
    logic                  unsignedQ;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [CPU_WIDTH-1:0]  datQ;
    logic                  misalignQ;
    logic                  faultQ;

    logic                  accept;
    logic                  rspCapture;
    logic                  reqMisaligned;
    logic                  inDone;
    logic [EN_W-1:0]       loadEn;

    assign reqMisaligned = is_misaligned(load_size_e'(bus.req_size), bus.req_addr[2:0], RV64 != 0);
    assign accept        = (state == ST_IDLE) && !flush && bus.req_vld;
    assign rspCapture    = (state == ST_WAIT) && !flush && bus.mem_rsp_vld;
    assign inDone        = (state == ST_DONE);
    assign loadEn        = EN_W'(size_to_load_en(sizeQ));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sizeQ     <= SIZE_B;
            unsignedQ <= 1'b0;
            addrQ     <= '0;
            datQ      <= '0;
            misalignQ <= 1'b0;
            faultQ    <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                sizeQ     <= load_size_e'(bus.req_size);
                unsignedQ <= bus.req_unsigned;
                addrQ     <= bus.req_addr;
                datQ      <= '0;
                misalignQ <= reqMisaligned;
                faultQ    <= 1'b0;
            end
            if (rspCapture) begin
                datQ   <= bus.mem_rsp_dat;
                faultQ <= bus.mem_rsp_err;
            end
        end
    end

    // A flush that races a memory handshake must still swallow the response
    // that is now owed, hence the DRAIN detours.
    always_comb begin
        nextState = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    nextState = reqMisaligned ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_rdy) begin
                    nextState = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    nextState = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rsp_vld) begin
                    nextState = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    nextState = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (flush || bus.ld_rdy) begin
                    nextState = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.mem_rsp_vld) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    assign bus.req_rdy      = (state == ST_IDLE) && !flush;
    assign bus.mem_req_vld  = (state == ST_REQ);
    assign bus.mem_req_addr = {addrQ[ADDR_WIDTH-1:LOW_BITS], {LOW_BITS{1'b0}}};

    // Result bundle is forced to zero outside DONE so idle outputs stay quiet.
    assign bus.ld_vld      = inDone;
    assign bus.ld_load_en  = (inDone && !misalignQ) ? loadEn : '0;
    assign bus.ld_unsigned = inDone && unsignedQ;
    assign bus.ld_addr     = inDone ? addrQ[LOW_BITS-1:0] : '0;
    assign bus.ld_mem_dat  = inDone ? datQ : '0;
    assign bus.ld_misalign = inDone && misalignQ;
    assign bus.ld_fault    = inDone && faultQ;

endmodule

// File: tb/tb_zion_riscv_isa_lib_load_mem_access.sv
// Directed bench for the load memory-access stage: an RV32 and an RV64
// instance, with a scoreboard of expected extract-stage results.
module tb_zion_riscv_isa_lib_load_mem_access;

    typedef struct {
        logic [3:0]  loadEn;
        logic        uns;
        logic [2:0]  addr;
        logic [63:0] dat;
        logic        mis;
        logic        flt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush0;
    logic flush1;
    int   checks;
    int   errors;
    exp_t expQ[$];

    zion_riscv_isa_lib_load_mem_access_if #(.RV64(0), .ADDR_WIDTH(32)) bus0 ();
    zion_riscv_isa_lib_load_mem_access_if #(.RV64(1), .ADDR_WIDTH(32)) bus1 ();

    zion_riscv_isa_lib_load_mem_access #(.RV64(0), .ADDR_WIDTH(32)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush0),
        .bus   (bus0)
    );

    zion_riscv_isa_lib_load_mem_access #(.RV64(1), .ADDR_WIDTH(32)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        bus0.req_vld      = 1'b1;
        bus0.req_addr     = addr;
        bus0.req_size     = size;
        bus0.req_unsigned = uns;
    endtask

    // Every extract-stage hand-off of the RV32 instance is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus0.ld_vld === 1'b1 && bus0.ld_rdy === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL sb_unexpected observed=ld_vld expected=none");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_load_en",  64'(bus0.ld_load_en),  64'(e.loadEn));
                checkOutput("sb_unsigned", 64'(bus0.ld_unsigned), 64'(e.uns));
                checkOutput("sb_addr",     64'(bus0.ld_addr),     64'(e.addr));
                checkOutput("sb_mem_dat",  64'(bus0.ld_mem_dat),  e.dat);
                checkOutput("sb_misalign", 64'(bus0.ld_misalign), 64'(e.mis));
                checkOutput("sb_fault",    64'(bus0.ld_fault),    64'(e.flt));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush0 = 1'b0;
        flush1 = 1'b0;
        bus0.req_vld = 1'b0; bus0.req_addr = '0; bus0.req_size = '0; bus0.req_unsigned = 1'b0;
        bus0.mem_req_rdy = 1'b0; bus0.mem_rsp_vld = 1'b0; bus0.mem_rsp_dat = '0; bus0.mem_rsp_err = 1'b0;
        bus0.ld_rdy = 1'b0;
        bus1.req_vld = 1'b0; bus1.req_addr = '0; bus1.req_size = '0; bus1.req_unsigned = 1'b0;
        bus1.mem_req_rdy = 1'b0; bus1.mem_rsp_vld = 1'b0; bus1.mem_rsp_dat = '0; bus1.mem_rsp_err = 1'b0;
        bus1.ld_rdy = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        checkOutput("rst_req_rdy",     64'(bus0.req_rdy),     64'd1);
        checkOutput("rst_mem_req_vld", 64'(bus0.mem_req_vld), 64'd0);
        checkOutput("rst_ld_vld",      64'(bus0.ld_vld),      64'd0);
        checkOutput("rst_ld_load_en",  64'(bus0.ld_load_en),  64'd0);
        checkOutput("rst_req_rdy64",   64'(bus1.req_rdy),     64'd1);

        // LW 0x100, memory ready at once, response the next cycle
        bus0.mem_req_rdy = 1'b1;
        applyStimulus(32'h100, 2'd2, 1'b0);
        expQ.push_back('{4'b0100, 1'b0, 3'b000, 64'hDEADBEEF, 1'b0, 1'b0});
        tick();
        bus0.req_vld = 1'b0;
        checkOutput("t1_mem_req_vld",  64'(bus0.mem_req_vld),  64'd1);
        checkOutput("t1_mem_req_addr", 64'(bus0.mem_req_addr), 64'h100);
        checkOutput("t1_req_rdy_busy", 64'(bus0.req_rdy),      64'd0);
        tick();
        checkOutput("t1_no_early_vld", 64'(bus0.ld_vld), 64'd0);
        bus0.mem_rsp_vld = 1'b1;
        bus0.mem_rsp_dat = 32'hDEADBEEF;
        tick();
        bus0.mem_rsp_vld = 1'b0;
        checkOutput("t1_latency_vld", 64'(bus0.ld_vld), 64'd1);
        bus0.ld_rdy = 1'b1;
        tick();
        bus0.ld_rdy = 1'b0;
        checkOutput("t1_back_idle", 64'(bus0.req_rdy), 64'd1);

        // LH 0x103: misaligned, no memory access, result in cycle 1
        applyStimulus(32'h103, 2'd1, 1'b0);
        expQ.push_back('{4'b0000, 1'b0, 3'b011, 64'h0, 1'b1, 1'b0});
        tick();
        bus0.req_vld = 1'b0;
        checkOutput("t2_no_mem_req",  64'(bus0.mem_req_vld), 64'd0);
        checkOutput("t2_ld_vld",      64'(bus0.ld_vld),      64'd1);
        checkOutput("t2_misalign",    64'(bus0.ld_misalign), 64'd1);
        bus0.ld_rdy = 1'b1;
        tick();
        bus0.ld_rdy = 1'b0;

        // flush in IDLE blocks acceptance
        flush0 = 1'b1;
        applyStimulus(32'h180, 2'd2, 1'b0);
        #1;
        checkOutput("fl_idle_req_rdy", 64'(bus0.req_rdy), 64'd0);
        tick();
        flush0 = 1'b0;
        bus0.req_vld = 1'b0;
        checkOutput("fl_idle_ignored", 64'(bus0.mem_req_vld), 64'd0);

        // RV64 LBU 0x1007 with memory stalling for 4 cycles
        bus1.req_vld = 1'b1; bus1.req_addr = 32'h1007; bus1.req_size = 2'd0; bus1.req_unsigned = 1'b1;
        tick();
        bus1.req_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_mem_req_vld",  64'(bus1.mem_req_vld),  64'd1);
            checkOutput("t3_mem_req_addr", 64'(bus1.mem_req_addr), 64'h1000);
            tick();
        end
        bus1.mem_req_rdy = 1'b1;
        tick();
        bus1.mem_req_rdy = 1'b0;
        bus1.mem_rsp_vld = 1'b1;
        bus1.mem_rsp_dat = 64'h1122334455667788;
        tick();
        bus1.mem_rsp_vld = 1'b0;
        checkOutput("t3_ld_vld",      64'(bus1.ld_vld),      64'd1);
        checkOutput("t3_ld_addr",     64'(bus1.ld_addr),     64'd7);
        checkOutput("t3_ld_unsigned", 64'(bus1.ld_unsigned), 64'd1);
        checkOutput("t3_ld_load_en",  64'(bus1.ld_load_en),  64'b0001);
        checkOutput("t3_ld_mem_dat",  64'(bus1.ld_mem_dat),  64'h1122334455667788);
        bus1.ld_rdy = 1'b1;
        tick();
        bus1.ld_rdy = 1'b0;
        checkOutput("t3_back_idle", 64'(bus1.req_rdy), 64'd1);

        // LW flushed in WAIT, response two cycles later is drained
        bus0.ld_rdy = 1'b1;
        applyStimulus(32'h200, 2'd2, 1'b0);
        tick();
        bus0.req_vld = 1'b0;
        tick();
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        checkOutput("t4_drain_rdy", 64'(bus0.req_rdy),     64'd0);
        checkOutput("t4_drain_req", 64'(bus0.mem_req_vld), 64'd0);
        tick();
        bus0.mem_rsp_vld = 1'b1;
        bus0.mem_rsp_dat = 32'h55;
        checkOutput("t4_drain_rdy2", 64'(bus0.req_rdy), 64'd0);
        tick();
        bus0.mem_rsp_vld = 1'b0;
        checkOutput("t4_idle_rdy", 64'(bus0.req_rdy), 64'd1);
        checkOutput("t4_no_ld_vld", 64'(bus0.ld_vld), 64'd0);
        bus0.ld_rdy = 1'b0;

        // access fault with a stalled extract stage
        applyStimulus(32'h300, 2'd2, 1'b0);
        expQ.push_back('{4'b0100, 1'b0, 3'b000, 64'hCAFEF00D, 1'b0, 1'b1});
        tick();
        bus0.req_vld = 1'b0;
        tick();
        bus0.mem_rsp_vld = 1'b1;
        bus0.mem_rsp_dat = 32'hCAFEF00D;
        bus0.mem_rsp_err = 1'b1;
        tick();
        bus0.mem_rsp_vld = 1'b0;
        bus0.mem_rsp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t5_hold_vld",   64'(bus0.ld_vld),     64'd1);
            checkOutput("t5_hold_fault", 64'(bus0.ld_fault),   64'd1);
            checkOutput("t5_hold_dat",   64'(bus0.ld_mem_dat), 64'hCAFEF00D);
            checkOutput("t5_req_rdy",    64'(bus0.req_rdy),    64'd0);
            tick();
        end
        bus0.ld_rdy = 1'b1;
        tick();
        bus0.ld_rdy = 1'b0;

        // reset while waiting on memory, then a clean LB
        applyStimulus(32'h400, 2'd2, 1'b0);
        tick();
        bus0.req_vld = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t6_req_rdy",      64'(bus0.req_rdy),      64'd1);
        checkOutput("t6_mem_req_vld",  64'(bus0.mem_req_vld),  64'd0);
        checkOutput("t6_mem_req_addr", 64'(bus0.mem_req_addr), 64'd0);
        checkOutput("t6_ld_vld",       64'(bus0.ld_vld),       64'd0);
        checkOutput("t6_ld_mem_dat",   64'(bus0.ld_mem_dat),   64'd0);
        applyStimulus(32'h401, 2'd0, 1'b0);
        expQ.push_back('{4'b0001, 1'b0, 3'b001, 64'hAB, 1'b0, 1'b0});
        tick();
        bus0.req_vld = 1'b0;
        checkOutput("t6_lb_addr", 64'(bus0.mem_req_addr), 64'h400);
        tick();
        bus0.mem_rsp_vld = 1'b1;
        bus0.mem_rsp_dat = 32'hAB;
        tick();
        bus0.mem_rsp_vld = 1'b0;
        checkOutput("t6_lb_vld", 64'(bus0.ld_vld), 64'd1);
        bus0.ld_rdy = 1'b1;
        tick();
        bus0.ld_rdy = 1'b0;

        repeat (2) tick();
        checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
